fft_bfly_sched: RTL and testbench
=================================

Name: fft_bfly_sched

Overview:
- Sequencer for the shared radix-2 DIT butterfly datapath in the in-place FFT.
- Walks all LOG2N stages × N/2 butterflies and issues read addresses to the dual-port data memory and the twiddle ROM.
- Issues the matching write-back addresses RD_LAT cycles later, aligned with the combinational butterfly output.
- Touches no sample data; input data is already stored in bit-reversed order before start.

Parameters:
- LOG2N, 3, log2 of FFT length N (N = 2^LOG2N, N/2 butterflies per stage).
- RD_LAT, 1, read latency in cycles of data memory and twiddle ROM (both identical, ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to begin a transform; ignored unless idle.
- busy  out  1  high while a transform is in progress.
- done  out  1  one-cycle pulse after the final write-back.
- rd_en  out  1  read strobe for data memory and twiddle ROM.
- rd_addr0  out  LOG2N  address of butterfly input x0.
- rd_addr1  out  LOG2N  address of butterfly input x1.
- tw_addr  out  LOG2N-1  twiddle ROM index, issued with rd_addr*.
- wr_en  out  1  write strobe for both butterfly outputs.
- wr_addr0  out  LOG2N  write address for out_x0.
- wr_addr1  out  LOG2N  write address for out_x1.
- stage  out  LOG2N bits (clog2)  current stage index, for debug/scaling control.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State to IDLE.
  - All outputs and delay-line contents to 0.
  - Applies mid-transform: pending writes are discarded and no done pulse is produced.
- All outputs are registered.
- States:
  - IDLE: start=1 → READ with s=0, k=0.
  - READ: rd_en=1 with addresses for (s,k), then k++.
    - At k=N/2-1 and s<LOG2N-1 → GAP.
    - At k=N/2-1 and s=LOG2N-1 → FLUSH.
  - GAP: rd_en=0 for exactly RD_LAT cycles (hazard gap: the last write of stage s commits before the first read of s+1). Then s++, k=0 → READ.
  - FLUSH: rd_en=0 for RD_LAT cycles → DONE.
  - DONE: done=1 for one cycle → IDLE.
- busy=1 in READ, GAP and FLUSH; 0 in IDLE and DONE.
- Address generation, stage s, butterfly k:
  - half = 1<<s.
  - pos = k & (half-1).
  - addr0 = ((k>>s)<<(s+1)) | pos.
  - addr1 = addr0 + half.
  - tw = pos << (LOG2N-1-s).
- Write path:
  - wr_en, wr_addr0 and wr_addr1 are rd_en, rd_addr0 and rd_addr1 delayed by exactly RD_LAT cycles through a shift register.
  - Write occurs in the cycle the read data is presented to the butterfly.
- Throughput: one butterfly per cycle in READ.
- Latency: done asserts LOG2N*(N/2+RD_LAT)+1 cycles after the edge sampling start.
- start while busy or in DONE: ignored; no restart and no effect on counters.
- start held high: a new transform begins only on the first IDLE cycle that sees it.
- No read and write to the same address occur in the same cycle within a stage (in-place butterfly pairs are disjoint).

Decomposition:
- Package fft_ctrl_pkg:
  - State enum (IDLE, READ, GAP, FLUSH, DONE).
  - Default LOG2N and RD_LAT.
  - Localparams N, HALF_N, STAGE_W.
- Sub-module fft_addr_gen: purely combinational (s,k) → addr0, addr1, tw, instantiated once.
- Scheduler FSM, counters and write delay line remain in fft_bfly_sched.

Test Plan:
- Reset state: rst_n=0 for 3 cycles → busy=done=rd_en=wr_en=0 and all addresses 0.
- Address sequence (N=8, RD_LAT=1), start pulse:
  - Stage 0 reads (0,1)(2,3)(4,5)(6,7) with tw 0,0,0,0.
  - One idle cycle.
  - Stage 1 reads (0,2)(1,3)(4,6)(5,7) with tw 0,2,0,2.
  - One idle cycle.
  - Stage 2 reads (0,4)(1,5)(2,6)(3,7) with tw 0,1,2,3.
  - done pulses exactly 16 cycles after start.
- Write alignment: every wr_en/wr_addr pair equals the rd pair from RD_LAT cycles earlier; check with RD_LAT=1 and RD_LAT=3 (N=8: done at 3*(4+3)+1=22).
- Start while busy: pulse start at cycle 5 of a run → sequence and done timing identical to an undisturbed run; exactly one done.
- Reset mid-operation: assert rst_n=0 during stage 1 → next cycle all outputs 0, no wr_en after reset, no done. A new start then yields the full 16-cycle sequence.
- End-to-end: scheduler driving memory plus butterfly_comb with an impulse at x[0]=1.0 (Q-format) → all 8 bins equal x[0], matching the golden model.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the in-place radix-2 FFT butterfly scheduler.
package fft_ctrl_pkg;

  localparam int LOG2N_DEF  = 3;
  localparam int RD_LAT_DEF = 1;
  localparam int N          = 1 << LOG2N_DEF;
  localparam int HALF_N     = N / 2;

  // Width helper that never collapses to a zero-width vector.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int STAGE_W = clog2_min1(LOG2N_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    GAP   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, butterfly) -> x0/x1 addresses and twiddle index.
module fft_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int  LOG2N = LOG2N_DEF,
  localparam int SW    = clog2_min1(LOG2N)
) (
  input  logic [SW-1:0]    s,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] addr0,
  output logic [LOG2N-1:0] addr1,
  output logic [LOG2N-2:0] tw
);

  int unsigned si;
  int unsigned ki;
  int unsigned half;
  int unsigned pos;
  int unsigned a0;

  // Butterfly k of stage s sits in group k>>s; pairs are spaced 'half' apart.
  always_comb begin
    si    = 32'(s);
    ki    = 32'(k);
    half  = 32'd1 << si;
    pos   = ki & (half - 32'd1);
    a0    = ((ki >> si) << (si + 32'd1)) | pos;
    addr0 = LOG2N'(a0);
    addr1 = LOG2N'(a0 + half);
    tw    = (LOG2N-1)'(pos << (32'(LOG2N - 1) - si));
  end

endmodule

// File: rtl/fft_bfly_sched.sv
// Stage/butterfly sequencer for the shared radix-2 DIT butterfly: issues reads, then the
// matching write-backs RD_LAT cycles later, with a hazard gap between stages.
module fft_bfly_sched
  import fft_ctrl_pkg::*;
#(
  parameter int  LOG2N  = LOG2N_DEF,
  parameter int  RD_LAT = RD_LAT_DEF,
  localparam int SW     = clog2_min1(LOG2N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr0,
  output logic [LOG2N-1:0] rd_addr1,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr0,
  output logic [LOG2N-1:0] wr_addr1,
  output logic [SW-1:0]    stage
);

  localparam int KW = LOG2N - 1;
  localparam int CW = clog2_min1(RD_LAT);
  localparam int DW = 1 + 2 * LOG2N;
  localparam logic [SW-1:0] LAST_S = SW'(LOG2N - 1);
  localparam logic [CW-1:0] LAST_C = CW'(RD_LAT - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr0_q, rd_addr0_d;
  logic [LOG2N-1:0] rd_addr1_q, rd_addr1_d;
  logic [KW-1:0]    tw_addr_q, tw_addr_d;
  logic [SW-1:0]    stage_q, stage_d;

  logic [DW-1:0]    dly_q [RD_LAT];
  logic [DW-1:0]    dly_d [RD_LAT];

  logic [LOG2N-1:0] gen_addr0;
  logic [LOG2N-1:0] gen_addr1;
  logic [KW-1:0]    gen_tw;

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s     (s_q),
    .k     (k_q),
    .addr0 (gen_addr0),
    .addr1 (gen_addr1),
    .tw    (gen_tw)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          s_d     = '0;
          k_d     = '0;
        end
      end
      READ: begin
        if (&k_q) begin
          cnt_d   = '0;
          state_d = (s_q == LAST_S) ? FLUSH : GAP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == LAST_C) begin
          state_d = READ;
          s_d     = s_q + 1'b1;
          k_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == LAST_C) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered copies of the current state, so they trail it by one cycle.
  always_comb begin
    rd_en_d    = (state_q == READ);
    rd_addr0_d = rd_en_d ? gen_addr0 : '0;
    rd_addr1_d = rd_en_d ? gen_addr1 : '0;
    tw_addr_d  = rd_en_d ? gen_tw : '0;
    stage_d    = s_q;
    busy_d     = (state_q == READ) || (state_q == GAP) || (state_q == FLUSH);
    done_d     = (state_q == DONE);
  end

  // Write-back delay line: tap 0 takes the issued read, the last tap drives the write port.
  assign dly_d[0] = {rd_en_q, rd_addr0_q, rd_addr1_q};
  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_dly
      assign dly_d[gi] = dly_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      tw_addr_q  <= '0;
      stage_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr0_q <= rd_addr0_d;
      rd_addr1_q <= rd_addr1_d;
      tw_addr_q  <= tw_addr_d;
      stage_q    <= stage_d;
      for (int i = 0; i < RD_LAT; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr0 = rd_addr0_q;
  assign rd_addr1 = rd_addr1_q;
  assign tw_addr  = tw_addr_q;
  assign stage    = stage_q;
  assign wr_en    = dly_q[RD_LAT-1][DW-1];
  assign wr_addr0 = dly_q[RD_LAT-1][2*LOG2N-1:LOG2N];
  assign wr_addr1 = dly_q[RD_LAT-1][LOG2N-1:0];

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench: two schedulers (RD_LAT=1 and 3) against a timeline model, plus an
// end-to-end impulse FFT through a bench-side memory and butterfly.
module tb_fft_bfly_sched;

  localparam int L = 3;
  localparam int N = 8;
  localparam int H = 4;

  typedef struct {
    bit rd;
    bit wr;
    bit busy;
    bit done;
    int a0;
    int a1;
    int tw;
    int w0;
    int w1;
    int st;
  } exp_t;

  typedef struct {
    int t;
    int a0;
    int a1;
    int tw;
  } rd_rec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       rd_en_o [2];
  logic       wr_en_o [2];
  logic [2:0] ra0     [2];
  logic [2:0] ra1     [2];
  logic [2:0] wa0     [2];
  logic [2:0] wa1     [2];
  logic [1:0] tw_o    [2];
  logic [1:0] st_o    [2];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  e0 [2]   = '{-1, -1};
  bit  chk_en   = 0;
  bit  cap_en   = 0;
  int  done_cnt [2] = '{0, 0};
  int  done_t   [2] = '{-1, -1};
  rd_rec_t cap_q [$];
  exp_t ex;
  int   tt;
  rd_rec_t rec;

  bit mem_load = 0;
  int mem_re [N];
  int mem_im [N];
  int x0r, x0i, x1r, x1i, twd;

  fft_bfly_sched #(.LOG2N(3), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_o[0]), .done(done_o[0]),
    .rd_en(rd_en_o[0]), .rd_addr0(ra0[0]), .rd_addr1(ra1[0]), .tw_addr(tw_o[0]),
    .wr_en(wr_en_o[0]), .wr_addr0(wa0[0]), .wr_addr1(wa1[0]), .stage(st_o[0])
  );

  fft_bfly_sched #(.LOG2N(3), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_o[1]), .done(done_o[1]),
    .rd_en(rd_en_o[1]), .rd_addr0(ra0[1]), .rd_addr1(ra1[1]), .tw_addr(tw_o[1]),
    .wr_en(wr_en_o[1]), .wr_addr0(wa0[1]), .wr_addr1(wa1[1]), .stage(st_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int t_done(input int lat);
    return L * (H + lat) + 1;
  endfunction

  // Butterfly k of stage s: groups of 2*half, pair members half apart, twiddle stride N/(2*half).
  task automatic spec_addr(input int s, input int k, output int a0, output int a1, output int tw);
    int half;
    int pos;
    half = 1 << s;
    pos  = k % half;
    a0   = (k / half) * (2 * half) + pos;
    a1   = a0 + half;
    tw   = pos * (H / half);
  endtask

  // Expected outputs t cycles after the edge that accepted start (t<0: idle).
  task automatic exp_at(input int t, input int lat, output exp_t e);
    int tr, a0, a1, tw;
    e.rd = 0; e.wr = 0; e.a0 = 0; e.a1 = 0; e.tw = 0; e.w0 = 0; e.w1 = 0; e.st = 0;
    e.busy = (t >= 1) && (t <= L * (H + lat));
    e.done = (t == t_done(lat));
    for (int s = 0; s < L; s++) begin
      for (int k = 0; k < H; k++) begin
        tr = 1 + s * (H + lat) + k;
        spec_addr(s, k, a0, a1, tw);
        if (t == tr) begin
          e.rd = 1; e.a0 = a0; e.a1 = a1; e.tw = tw; e.st = s;
        end
        if (t == tr + lat) begin
          e.wr = 1; e.w0 = a0; e.w1 = a1;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s L%0d busy", tag, lat_of(i)), int'(busy_o[i]), 0);
      check($sformatf("%s L%0d done", tag, lat_of(i)), int'(done_o[i]), 0);
      check($sformatf("%s L%0d rd_en", tag, lat_of(i)), int'(rd_en_o[i]), 0);
      check($sformatf("%s L%0d wr_en", tag, lat_of(i)), int'(wr_en_o[i]), 0);
      check($sformatf("%s L%0d addrs", tag, lat_of(i)),
            int'(ra0[i]) + int'(ra1[i]) + int'(wa0[i]) + int'(wa1[i]) + int'(tw_o[i]) + int'(st_o[i]), 0);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int q14_mul(input int a, input int b);
    return (a * b) >>> 14;
  endfunction

  function automatic int tw_re(input int i);
    case (i)
      0: return 16384;
      1: return 11585;
      2: return 0;
      default: return -11585;
    endcase
  endfunction

  function automatic int tw_im(input int i);
    case (i)
      0: return 0;
      1: return -11585;
      2: return -16384;
      default: return -11585;
    endcase
  endfunction

  // Reference timeline: a transform is accepted only when the scheduler is back in IDLE.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      e0[0]  <= -1;
      e0[1]  <= -1;
      chk_en <= 1'b1;
    end else if (start) begin
      for (int i = 0; i < 2; i++) begin
        if (e0[i] < 0 || (cyc + 1 - e0[i]) > t_done(lat_of(i))) e0[i] <= cyc + 1;
      end
    end
  end

  // Data memory + butterfly driven by the RD_LAT=1 scheduler.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int j = 0; j < N; j++) begin
        mem_re[j] <= (j == 0) ? 16384 : 0;
        mem_im[j] <= 0;
      end
    end else begin
      if (rd_en_o[0]) begin
        x0r <= mem_re[ra0[0]];
        x0i <= mem_im[ra0[0]];
        x1r <= mem_re[ra1[0]];
        x1i <= mem_im[ra1[0]];
        twd <= int'(tw_o[0]);
      end
      if (wr_en_o[0]) begin
        mem_re[wa0[0]] <= x0r + q14_mul(tw_re(twd), x1r) - q14_mul(tw_im(twd), x1i);
        mem_im[wa0[0]] <= x0i + q14_mul(tw_re(twd), x1i) + q14_mul(tw_im(twd), x1r);
        mem_re[wa1[0]] <= x0r - q14_mul(tw_re(twd), x1r) + q14_mul(tw_im(twd), x1i);
        mem_im[wa1[0]] <= x0i - q14_mul(tw_re(twd), x1i) - q14_mul(tw_im(twd), x1r);
      end
    end
  end

  // Single compare process: every DUT output against the model, every cycle after reset.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        tt = (e0[i] < 0) ? -1 : cyc - e0[i];
        exp_at(tt, lat_of(i), ex);
        check($sformatf("L%0d rd_en t=%0d", lat_of(i), tt), int'(rd_en_o[i]), int'(ex.rd));
        check($sformatf("L%0d wr_en t=%0d", lat_of(i), tt), int'(wr_en_o[i]), int'(ex.wr));
        check($sformatf("L%0d busy t=%0d", lat_of(i), tt), int'(busy_o[i]), int'(ex.busy));
        check($sformatf("L%0d done t=%0d", lat_of(i), tt), int'(done_o[i]), int'(ex.done));
        if (ex.rd) begin
          check($sformatf("L%0d rd_addr0 t=%0d", lat_of(i), tt), int'(ra0[i]), ex.a0);
          check($sformatf("L%0d rd_addr1 t=%0d", lat_of(i), tt), int'(ra1[i]), ex.a1);
          check($sformatf("L%0d tw_addr t=%0d", lat_of(i), tt), int'(tw_o[i]), ex.tw);
          check($sformatf("L%0d stage t=%0d", lat_of(i), tt), int'(st_o[i]), ex.st);
        end
        if (ex.wr) begin
          check($sformatf("L%0d wr_addr0 t=%0d", lat_of(i), tt), int'(wa0[i]), ex.w0);
          check($sformatf("L%0d wr_addr1 t=%0d", lat_of(i), tt), int'(wa1[i]), ex.w1);
        end
        if (done_o[i]) begin
          done_cnt[i]++;
          done_t[i] = tt;
        end
        if (i == 0 && cap_en && rd_en_o[0]) begin
          rec.t  = tt;
          rec.a0 = int'(ra0[0]);
          rec.a1 = int'(ra1[0]);
          rec.tw = int'(tw_o[0]);
          cap_q.push_back(rec);
        end
      end
    end
  end

  initial begin
    int lit_a0 [3][4];
    int lit_a1 [3][4];
    int lit_tw [3][4];
    int lit_t  [3][4];
    int ma0, ma1, mtw, idx;
    lit_a0 = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    lit_a1 = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    lit_tw = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};
    lit_t  = '{'{1, 2, 3, 4}, '{6, 7, 8, 9}, '{11, 12, 13, 14}};

    // Pin the model against the hand-derived N=8 table and latencies.
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) begin
        spec_addr(s, k, ma0, ma1, mtw);
        check($sformatf("model a0 s%0d k%0d", s, k), ma0, lit_a0[s][k]);
        check($sformatf("model a1 s%0d k%0d", s, k), ma1, lit_a1[s][k]);
        check($sformatf("model tw s%0d k%0d", s, k), mtw, lit_tw[s][k]);
      end
    end
    check("model t_done lat1", t_done(1), 16);
    check("model t_done lat3", t_done(3), 22);

    rst_n = 1'b0;
    start = 1'b0;
    cycles(3);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Undisturbed run: literal read order, gaps and done timing.
    cap_en = 1'b1;
    done_cnt = '{0, 0};
    pulse_start();
    cycles(30);
    cap_en = 1'b0;
    check("run1 read count", cap_q.size(), 12);
    for (int j = 0; j < 12; j++) begin
      if (j < cap_q.size()) begin
        idx = j / 4;
        check($sformatf("run1 rd%0d time", j), cap_q[j].t, lit_t[idx][j % 4]);
        check($sformatf("run1 rd%0d a0", j), cap_q[j].a0, lit_a0[idx][j % 4]);
        check($sformatf("run1 rd%0d a1", j), cap_q[j].a1, lit_a1[idx][j % 4]);
        check($sformatf("run1 rd%0d tw", j), cap_q[j].tw, lit_tw[idx][j % 4]);
      end
    end
    check("run1 done_t L1", done_t[0], 16);
    check("run1 done_t L3", done_t[1], 22);
    check("run1 done count L1", done_cnt[0], 1);
    check("run1 done count L3", done_cnt[1], 1);

    // Start while busy is ignored.
    done_cnt = '{0, 0};
    pulse_start();
    cycles(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(30);
    check("busy-start done count L1", done_cnt[0], 1);
    check("busy-start done count L3", done_cnt[1], 1);
    check("busy-start done_t L1", done_t[0], 16);
    check("busy-start done_t L3", done_t[1], 22);

    // Reset during stage 1: everything clears and no done follows.
    done_cnt = '{0, 0};
    pulse_start();
    cycles(6);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    cycles(30);
    check("midreset done count L1", done_cnt[0], 0);
    check("midreset done count L3", done_cnt[1], 0);
    pulse_start();
    cycles(30);
    check("post-reset done count L1", done_cnt[0], 1);
    check("post-reset done_t L1", done_t[0], 16);

    // Start held high: back-to-back transforms from each first IDLE cycle.
    done_cnt = '{0, 0};
    @(negedge clk);
    start = 1'b1;
    cycles(68);
    start = 1'b0;
    cycles(30);
    check("held-start done count L1", done_cnt[0], 4);
    check("held-start done count L3", done_cnt[1], 3);

    // Random start pulses and occasional resets.
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 11) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    cycles(30);

    // End-to-end impulse transform through the RD_LAT=1 scheduler.
    @(negedge clk);
    mem_load = 1'b1;
    @(negedge clk);
    mem_load = 1'b0;
    pulse_start();
    cycles(30);
    for (int j = 0; j < N; j++) begin
      check($sformatf("impulse bin%0d re", j), mem_re[j], 16384);
      check($sformatf("impulse bin%0d im", j), mem_im[j], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
